add_sub_serial: RTL

ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

---
 rtl/add_serial_pkg.sv | 14 +
 rtl/fa_bit.sv | 14 +
 rtl/add_sub_serial.sv | 127 ++++++++++++
 3 files changed

// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default operand
// width and the FSM state encoding.
package add_serial_pkg;

    localparam int ADD_SERIAL_WIDTH = 8;

    // Two-bit state encoding; the fourth code (2'd3) is unused and recovers to IDLE.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder used by the serial datapath to produce the current
// result bit and the carry into the next bit position.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_sub_serial.sv
// Bit-serial adder/subtractor. Operands are latched on a start request,
// processed one bit per clock LSB-first through a single full adder, and the
// result is shifted into the output register from the top. Subtraction is
// done as a + ~b + 1 by inverting b at load time and seeding the carry with 1.
module add_sub_serial
    import add_serial_pkg::*;
#(
    parameter int WIDTH = ADD_SERIAL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               sum_bit;
    logic               carry_nxt;
    logic               load;

    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    // A start request is honoured from IDLE and also directly from DONE,
    // which gives back-to-back operation without passing through IDLE.
    assign load = en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and datapath logic for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    out_d   = '0;
                    count_d = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                out_d   = {sum_bit, out_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    cout_d  = carry_nxt;
                    ovf_d   = carry_q ^ carry_nxt;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                a_d     = '0;
                b_d     = '0;
                out_d   = '0;
                count_d = '0;
                carry_d = 1'b0;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);

endmodule
